// File: rtl/operand_serializer_if.sv
// Word-side and bit-side handshake bundle between an operand source, operand_serializer and the serial multiplier.
interface operand_serializer_if #(
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] iv_a;
  logic [DATA_WIDTH-1:0] iv_b;
  logic                  i_valid;
  logic                  o_ready;
  logic                  o_din_a;
  logic                  o_din_b;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_last;
  logic [LW-1:0]         ov_level;

  // master drives operands and the downstream ready; slave is the serializer
  modport master (
    output iv_a, iv_b, i_valid, i_ready,
    input  o_ready, o_din_a, o_din_b, o_valid, o_last, ov_level
  );

  modport slave (
    input  iv_a, iv_b, i_valid, i_ready,
    output o_ready, o_din_a, o_din_b, o_valid, o_last, ov_level
  );
endinterface

// File: rtl/operand_serializer.sv
// Buffers operand pairs in a FIFO and shifts them out as lock-stepped serial streams; push-to-first-bit one cycle, no bubble between words.
// Word side stalls only when the FIFO is full, bit side holds on i_ready low; SER_MSB_FIRST_EN selects MSB-first order.
module operand_serializer #(
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  operand_serializer_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [DATA_WIDTH-1:0] mem_a [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_b [FIFO_DEPTH];
  logic [LW-1:0]         wr_ptr;
  logic [LW-1:0]         rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  rdy;
  logic                  push;
  logic                  pop;
  logic                  beat;
  logic                  at_last;

  logic [0:0]            state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] sr_a;
  logic [DATA_WIDTH-1:0] sr_b;

  // extra pointer MSB distinguishes full from empty when the index bits match
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign rdy   = i_en & ~full;
  assign push  = rdy & bus.i_valid;

  assign at_last = (state == ST_SHIFT) && (cnt == CNT_LAST);
  assign beat    = (state == ST_SHIFT) & i_en & bus.i_ready;
  // reload on the final beat keeps consecutive words gap-free
  assign pop     = i_en & ~empty & ((state == ST_IDLE) | (beat & at_last));

  assign bus.o_ready  = rdy;
  assign bus.ov_level = wr_ptr - rd_ptr;
  assign bus.o_valid  = i_en & (state == ST_SHIFT);
  assign bus.o_last   = at_last;
`ifdef SER_MSB_FIRST_EN
  assign bus.o_din_a  = sr_a[DATA_WIDTH-1];
  assign bus.o_din_b  = sr_b[DATA_WIDTH-1];
`else
  assign bus.o_din_a  = sr_a[0];
  assign bus.o_din_b  = sr_b[0];
`endif

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_a[wr_ptr[AW-1:0]] <= bus.iv_a;
      mem_b[wr_ptr[AW-1:0]] <= bus.iv_b;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sr_a  <= '0;
      sr_b  <= '0;
    end else if (pop) begin
      state <= ST_SHIFT;
      cnt   <= '0;
      sr_a  <= mem_a[rd_ptr[AW-1:0]];
      sr_b  <= mem_b[rd_ptr[AW-1:0]];
    end else if (beat) begin
`ifdef SER_MSB_FIRST_EN
      sr_a <= {sr_a[DATA_WIDTH-2:0], 1'b0};
      sr_b <= {sr_b[DATA_WIDTH-2:0], 1'b0};
`else
      sr_a <= {1'b0, sr_a[DATA_WIDTH-1:1]};
      sr_b <= {1'b0, sr_b[DATA_WIDTH-1:1]};
`endif
      if (at_last) begin
        cnt   <= '0;
        state <= ST_IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_operand_serializer.sv
// Directed bench for operand_serializer with a queue of pushed pairs supplying expected serial bits.
module tb_operand_serializer;
  localparam int DW = 4;
  localparam int FD = 4;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_en;

  always #5 i_clk = ~i_clk;

  operand_serializer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  operand_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [2*DW-1:0] q[$];
  int bidx = 0;
  int words_done = 0;
  int beats = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input logic [DW-1:0] w, input int i);
`ifdef SER_MSB_FIRST_EN
    return w[DW-1-i];
`else
    return w[i];
`endif
  endfunction

  // one clock: score a beat against the head word, record an accepted push
  task automatic step();
    logic acc;
    #1;
    if (bus.o_valid && bus.i_ready) begin
      if (q.size() == 0) begin
        check("unexpected_beat", bus.o_valid, 1'b0);
      end else begin
        check("din_a", bus.o_din_a, sel(q[0][2*DW-1:DW], bidx));
        check("din_b", bus.o_din_b, sel(q[0][DW-1:0], bidx));
        check("last", bus.o_last, bidx == DW-1);
        beats++;
        bidx++;
        if (bidx == DW) begin
          void'(q.pop_front());
          bidx = 0;
          words_done++;
        end
      end
    end
    acc = bus.i_valid && bus.o_ready;
    if (acc) q.push_back({bus.iv_a, bus.iv_b});
    @(negedge i_clk);
    if (acc) bus.i_valid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input int exp_lvl);
    bus.iv_a = a;
    bus.iv_b = b;
    bus.i_valid = 1'b1;
    #1;
    check("rdy_before_push", bus.o_ready, 1'b1);
    step();
    #1;
    check("level_after_push", bus.ov_level, exp_lvl);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int ea [4];
    int eb [4];
    logic [DW-1:0] pa [5];
    logic [DW-1:0] pb [5];
    int elv [5];
    int n;
    int b0;
    int w0;
    logic held;

    i_rst = 1'b0;
    i_en = 1'b0;
    bus.iv_a = '0;
    bus.iv_b = '0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_last", bus.o_last, 1'b0);
    check("rst_din_a", bus.o_din_a, 1'b0);
    check("rst_din_b", bus.o_din_b, 1'b0);
    check("rst_level", bus.ov_level, 0);
    check("rst_ready_disabled", bus.o_ready, 1'b0);

    // single word a=0110 b=1011
    @(negedge i_clk);
    i_rst = 1'b1;
    i_en = 1'b1;
    #1;
    check("ready_after_reset", bus.o_ready, 1'b1);
    ea = '{0, 1, 1, 0};
`ifdef SER_MSB_FIRST_EN
    eb = '{1, 0, 1, 1};
`else
    eb = '{1, 1, 0, 1};
`endif
    bus.iv_a = 4'b0110;
    bus.iv_b = 4'b1011;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    #1;
    check("t1_not_yet_valid", bus.o_valid, 1'b0);
    check("t1_level_one", bus.ov_level, 1);
    @(negedge i_clk);
    #1;
    check("t1_level_popped", bus.ov_level, 0);
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", bus.o_valid, 1'b1);
      check("t1_din_a", bus.o_din_a, ea[i]);
      check("t1_din_b", bus.o_din_b, eb[i]);
      check("t1_last", bus.o_last, i == 3);
      @(negedge i_clk);
      #1;
    end
    check("t1_valid_after", bus.o_valid, 1'b0);
    check("t1_last_after", bus.o_last, 1'b0);

    // five pairs with downstream stalled: one in shifter, four fill the FIFO
    bus.i_ready = 1'b0;
    pa = '{4'h3, 4'h5, 4'hA, 4'hC, 4'h9};
    pb = '{4'hE, 4'h1, 4'h7, 4'h2, 4'hF};
    elv = '{1, 1, 2, 3, 4};
    w0 = words_done;
    for (int p = 0; p < 5; p++) send(pa[p], pb[p], elv[p]);
    check("t2_full_ready", bus.o_ready, 1'b0);
    check("t2_full_level", bus.ov_level, 4);
    check("t2_stall_valid", bus.o_valid, 1'b1);
    check("t2_stall_din_a", bus.o_din_a, sel(4'h3, 0));
    bus.iv_a = 4'h6;
    bus.iv_b = 4'h8;
    bus.i_valid = 1'b1;
    step();
    step();
    #1;
    check("t2_held_level", bus.ov_level, 4);
    check("t2_held_ready", bus.o_ready, 1'b0);
    bus.i_ready = 1'b1;
    repeat (3) step();
    #1;
    check("t2_pre_pop_ready", bus.o_ready, 1'b0);
    // pop on a full FIFO while a push is offered: push must be refused
    step();
    #1;
    held = bus.i_valid;
    check("t2_push_refused", held, 1'b1);
    check("t2_level_after_pop", bus.ov_level, 3);
    check("t2_ready_after_pop", bus.o_ready, 1'b1);
    b0 = beats;
    n = 0;
    while ((q.size() != 0 || bus.i_valid) && n < 100) begin
      #1;
      check("t3_no_bubble", bus.o_valid, 1'b1);
      step();
      n++;
    end
    check("t3_drain_in_time", n < 100, 1'b1);
    check("t3_beats", beats - b0, 20);
    check("t2_words", words_done - w0, 6);
    #1;
    check("t3_idle_valid", bus.o_valid, 1'b0);
    check("t3_idle_level", bus.ov_level, 0);

    // stall pattern 1,0,0,1 mid-word
    w0 = words_done;
    bus.iv_a = 4'b1001;
    bus.iv_b = 4'b0101;
    bus.i_valid = 1'b1;
    step();
    step();
    step();
    bus.i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t4_stall_valid", bus.o_valid, 1'b1);
      check("t4_stall_din_a", bus.o_din_a, sel(4'b1001, 1));
      check("t4_stall_din_b", bus.o_din_b, sel(4'b0101, 1));
      check("t4_stall_last", bus.o_last, 1'b0);
      step();
    end
    bus.i_ready = 1'b1;
    repeat (3) step();
    check("t4_words", words_done - w0, 1);
    check("t4_done_valid", bus.o_valid, 1'b0);

    // enable dropped for three cycles after two bits
    w0 = words_done;
    bus.iv_a = 4'hB;
    bus.iv_b = 4'h4;
    bus.i_valid = 1'b1;
    repeat (4) step();
    i_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5_en_low_valid", bus.o_valid, 1'b0);
      check("t5_en_low_ready", bus.o_ready, 1'b0);
      step();
    end
    i_en = 1'b1;
    #1;
    check("t5_resume_valid", bus.o_valid, 1'b1);
    check("t5_resume_din_a", bus.o_din_a, sel(4'hB, 2));
    check("t5_resume_din_b", bus.o_din_b, sel(4'h4, 2));
    repeat (2) step();
    check("t5_words", words_done - w0, 1);

    // reset at bit 2 with two pairs queued
    bus.i_ready = 1'b0;
    send(4'h1, 4'h2, 1);
    send(4'h4, 4'h8, 1);
    send(4'h7, 4'hD, 2);
    bus.i_ready = 1'b1;
    step();
    step();
    #1;
    check("t6_mid_valid", bus.o_valid, 1'b1);
    check("t6_mid_level", bus.ov_level, 2);
    i_rst = 1'b0;
    #1;
    check("t6_rst_valid", bus.o_valid, 1'b0);
    check("t6_rst_last", bus.o_last, 1'b0);
    check("t6_rst_din_a", bus.o_din_a, 1'b0);
    check("t6_rst_din_b", bus.o_din_b, 1'b0);
    check("t6_rst_level", bus.ov_level, 0);
    q.delete();
    bidx = 0;
    @(negedge i_clk);
    i_rst = 1'b1;
    w0 = words_done;
    bus.iv_a = 4'hD;
    bus.iv_b = 4'h6;
    bus.i_valid = 1'b1;
    repeat (6) step();
    check("t6_words_after_reset", words_done - w0, 1);
    #1;
    check("t6_final_valid", bus.o_valid, 1'b0);
    check("t6_final_level", bus.ov_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
